// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: sequential instruction fetch stage. Issues credit-limited
// fetch requests, buffers in-order responses with their PCs in a small FIFO,
// and on a redirect flushes the FIFO and drops every response still in flight.
module inst_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          drop;
    logic          redirect_pc_unused;

    // Instructions are word aligned; the low redirect bits carry no information.
    assign redirect_pc_unused = ^redirect_pc[1:0];

    assign inst_valid = (count_q != '0);
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];

    // Request credit check and the handshake events of the current cycle.
    always_comb begin
        credit_used   = {1'b0, count_q} + {1'b0, outst_q};
        mem_req_valid = !rest && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
        mem_req_addr  = fetch_pc_q;
        req_fire      = mem_req_valid && mem_req_ready;
        drop          = mem_resp_valid && (drop_q != '0);
        push          = mem_resp_valid && (drop_q == '0) && !redirect_valid;
        pop           = inst_valid && inst_ready && !redirect_valid;
    end

    // Next-state for PCs, pointers and counters; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_ptr_d   = rd_ptr_q;
            // A response landing now retires one request; the rest become stale.
            if (mem_resp_valid && (outst_q != '0)) begin
                outst_d = outst_q - ONE_C;
            end
            drop_d = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PONE_C;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PONE_C;
            end
            if (drop) begin
                drop_d = drop_q - ONE_C;
            end
            if (push && !pop) begin
                count_d = count_q + ONE_C;
            end else if (pop && !push) begin
                count_d = count_q - ONE_C;
            end
            if (req_fire && !mem_resp_valid) begin
                outst_d = outst_q + ONE_C;
            end else if (!req_fire && mem_resp_valid) begin
                outst_d = outst_q - ONE_C;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rest) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rest) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= mem_resp_data;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // A response landing in a full FIFO means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rest && push) begin
            assert (count_q != DEPTH_C) else $error("inst_fetch_buf: push into full FIFO");
        end
    end
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Bench for inst_fetch_buf: an in-order memory with configurable latency plus
// a queue-based model of which fetched words must reach the core, in order.
module tb_inst_fetch_buf;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;

    logic        clk;
    logic        rest;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    inst_fetch_buf #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rest(rest),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    int last_due = 0;

    // memory side: pending requests with the cycle their response is due
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    // model: words owed to the core, and requests in flight ({stale, addr})
    logic [63:0] m_fifo [$];
    logic [32:0] m_infl [$];
    logic [31:0] m_fetch_pc;

    logic        s_req_valid, s_inst_valid, s_fire;
    logic [31:0] s_req_addr, s_inst, s_inst_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit ir, input bit mr);
        bit          resp_v, exp_rv, exp_iv, fire, stale;
        logic [31:0] a;
        int          due;
        @(negedge clk);
        resp_v         = !r && (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        rest           = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = ir;
        mem_req_ready  = mr;
        mem_resp_valid = resp_v;
        mem_resp_data  = resp_v ? memf(pend_addr[0]) : $urandom();
        #1;
        exp_rv = !r && !rv && ((m_fifo.size() + m_infl.size()) < DEPTH);
        exp_iv = (m_fifo.size() != 0);
        chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("mem_req_addr", mem_req_addr, m_fetch_pc);
        chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("inst_pc", inst_pc, m_fifo[0][63:32]);
            chk("inst", inst, m_fifo[0][31:0]);
        end
        s_req_valid  = mem_req_valid;
        s_req_addr   = mem_req_addr;
        s_inst_valid = inst_valid;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        s_fire       = mem_req_valid && mr;
        fire         = exp_rv && mr;
        if (r) begin
            pend_addr.delete();
            pend_due.delete();
            m_fifo.delete();
            m_infl.delete();
            m_fetch_pc = RESET_PC;
            last_due   = 0;
        end else begin
            if (resp_v) begin
                a   = pend_addr.pop_front();
                due = pend_due.pop_front();
                if (m_infl.size() != 0) begin
                    {stale, a} = m_infl.pop_front();
                    if (!stale && !rv) m_fifo.push_back({a, memf(a)});
                end
            end
            if (exp_iv && ir && !rv) begin
                a = m_fifo[0][63:32];
                m_fifo.delete(0);
            end
            if (resp_v && !rv && m_fifo.size() > 0) begin
                // a freshly pushed word sits behind any remaining entries
            end
            if (s_fire) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(mem_req_addr);
                pend_due.push_back(due);
            end
            if (fire) begin
                m_infl.push_back({1'b0, m_fetch_pc});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (rv) begin
                m_fifo.delete();
                for (int i = 0; i < m_infl.size(); i++) m_infl[i][32] = 1'b1;
                m_fetch_pc = {rpc[31:2], 2'b00};
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] fa [$];
        logic [31:0] da [$];
        logic [31:0] e_exp [3];
        int          nfire;
        logic [31:0] last_addr;
        bit          found;

        rest = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
        m_fetch_pc = RESET_PC;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);

        // sequential streaming, 1-cycle memory, core always ready
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 32'd0, 1, 1);
            if (i < 3) chk("a_req_addr", s_req_addr, 32'h8000_0000 + 32'(4 * i));
            if (i == 1) chk("a_early_valid", 32'(s_inst_valid), 32'd0);
            if (i >= 2) begin
                chk("a_valid", 32'(s_inst_valid), 32'd1);
                chk("a_inst_pc", s_inst_pc, 32'h8000_0000 + 32'(4 * (i - 2)));
            end
        end

        // reset mid-stream with requests in flight and FIFO occupied
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 0, 1);
        step(1, 0, 32'd0, 0, 1);
        step(1, 0, 32'd0, 0, 1);
        chk("r_req_valid", 32'(s_req_valid), 32'd0);
        chk("r_inst_valid", 32'(s_inst_valid), 32'd0);
        chk("r_inst", s_inst, 32'd0);
        chk("r_inst_pc", s_inst_pc, 32'd0);

        // core stalled: credit limit of DEPTH requests
        lat_lo = 1; lat_hi = 1;
        nfire = 0; last_addr = '0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 32'd0, 0, 1);
            if (i == 0) chk("b_restart_addr", s_req_addr, 32'h8000_0000);
            if (s_fire) begin nfire++; last_addr = s_req_addr; end
        end
        chk("b_nfire", 32'(nfire), 32'd4);
        chk("b_last_addr", last_addr, 32'h8000_000C);
        chk("b_full_req_valid", 32'(s_req_valid), 32'd0);
        chk("b_full_inst_pc", s_inst_pc, 32'h8000_0000);
        step(0, 0, 32'd0, 1, 1);
        chk("b_pop_req_valid", 32'(s_req_valid), 32'd0);
        step(0, 0, 32'd0, 0, 1);
        chk("b_refill_valid", 32'(s_req_valid), 32'd1);
        chk("b_refill_addr", s_req_addr, 32'h8000_0010);
        step(0, 0, 32'd0, 0, 1);
        chk("b_refill_once", 32'(s_req_valid), 32'd0);
        chk("b_next_inst_pc", s_inst_pc, 32'h8000_0004);

        // redirect with three requests in flight
        step(1, 0, 32'd0, 1, 1);
        lat_lo = 4; lat_hi = 4;
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 1, 1);
        step(0, 1, 32'h8000_0100, 1, 1);
        chk("c_redir_req_valid", 32'(s_req_valid), 32'd0);
        step(0, 0, 32'd0, 1, 1);
        chk("c_flushed", 32'(s_inst_valid), 32'd0);
        chk("c_new_addr", s_req_addr, 32'h8000_0100);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 32'd0, 1, 1);
            if (s_inst_valid) begin
                found = 1;
                chk("c_first_pc", s_inst_pc, 32'h8000_0100);
            end
        end
        chk("c_delivered", 32'(found), 32'd1);

        // redirect coinciding with a response and a pop
        lat_lo = 2; lat_hi = 2;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pend_addr.size() != 0 && pend_due[0] <= cyc && m_fifo.size() != 0 && m_infl.size() >= 2)
                found = 1;
            else
                step(0, 0, 32'd0, 1, 1);
        end
        chk("d_setup", 32'(found), 32'd1);
        step(0, 1, 32'h8000_0200, 1, 1);
        step(0, 0, 32'd0, 1, 1);
        chk("d_flushed", 32'(s_inst_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 32'd0, 1, 1);
            if (s_inst_valid) begin
                found = 1;
                chk("d_first_pc", s_inst_pc, 32'h8000_0200);
            end
        end
        chk("d_delivered", 32'(found), 32'd1);

        // address wrap; low redirect bits are ignored
        lat_lo = 1; lat_hi = 1;
        step(0, 1, 32'hFFFF_FFFA, 1, 1);
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 32'd0, 1, 1);
            if (s_fire) fa.push_back(s_req_addr);
            if (s_inst_valid) da.push_back(s_inst_pc);
        end
        e_exp[0] = 32'hFFFF_FFF8; e_exp[1] = 32'hFFFF_FFFC; e_exp[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            chk("e_fetch_addr", (k < fa.size()) ? fa[k] : 32'hDEAD_BEEF, e_exp[k]);
            chk("e_inst_pc", (k < da.size()) ? da[k] : 32'hDEAD_BEEF, e_exp[k]);
        end

        // randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            bit          r, rv, ir, mr;
            logic [31:0] rpc;
            if (i % 50 == 0) begin
                lat_lo = $urandom_range(2, 1);
                lat_hi = lat_lo + $urandom_range(2, 0);
            end
            r   = ($urandom_range(199, 0) == 0);
            rv  = !r && ($urandom_range(15, 0) == 0);
            rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            ir  = ($urandom_range(3, 0) != 0);
            mr  = ($urandom_range(3, 0) != 0);
            step(r, rv, rpc, ir, mr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
